// File: rtl/cmos_cap_pkg.sv
// Shared types and sizing helpers for the CMOS DVP capture path.
package cmos_cap_pkg;

  localparam int PIX_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_VS,
    CAPTURE,
    SKIPPING
  } cap_state_t;

  function automatic int pix_per_word(input int dout_w);
    return dout_w / PIX_W;
  endfunction

  function automatic int total_cnt_w(input int h_active, input int v_active);
    return $clog2(h_active * v_active + 1);
  endfunction

endpackage

// File: rtl/pix_word_packer.sv
// Shifts RGB565 pixels into a word MSB-first; a flush emits the partial word
// left-aligned with zero padding (all zeros if nothing is held).
module pix_word_packer
  import cmos_cap_pkg::*;
#(
  parameter int DOUT_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_vld,
  input  logic [PIX_W-1:0]  pix,
  input  logic              flush,
  output logic              fire,
  output logic [DOUT_W-1:0] word,
  output logic              word_vld
);

  localparam int PPW = pix_per_word(DOUT_W);
  localparam int FW  = $clog2(PPW + 1);
  localparam int SW  = $clog2(DOUT_W + 1);

  logic [DOUT_W-1:0] shift_reg, shift_next;
  logic [FW-1:0]     fill_reg, fill_next;
  logic [SW-1:0]     pad_shift;

  always_comb begin
    shift_next = shift_reg;
    fill_next  = fill_reg;
    if (pix_vld) begin
      shift_next = (shift_reg << PIX_W) | DOUT_W'(pix);
      fill_next  = fill_reg + 1'b1;
    end
    fire      = flush || (fill_next == FW'(PPW));
    // Empty slots sit in the low bits, so shift the held pixels up past them.
    pad_shift = SW'(FW'(PPW) - fill_next) * SW'(PIX_W);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg <= '0;
      fill_reg  <= '0;
      word      <= '0;
      word_vld  <= 1'b0;
    end else begin
      word_vld <= fire;
      if (fire) begin
        word      <= shift_next << pad_shift;
        shift_reg <= '0;
        fill_reg  <= '0;
      end else begin
        shift_reg <= shift_next;
        fill_reg  <= fill_next;
      end
    end
  end

endmodule

// File: rtl/cmos_pack_capture.sv
// OV5640 DVP capture: byte pairing, frame decimation, line/frame length
// checks and packing into sop/eop-tagged DOUT_W-bit words.
module cmos_pack_capture
  import cmos_cap_pkg::*;
#(
  parameter int DOUT_W   = 128,
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 720,
  parameter int SKIP     = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        din,
  output logic [DOUT_W-1:0] dout,
  output logic              dout_vld,
  output logic              dout_sop,
  output logic              dout_eop,
  output logic              frame_done,
  output logic              line_err,
  output logic              frame_err,
  output logic [15:0]       frame_cnt
);

  localparam int TOTAL = H_ACTIVE * V_ACTIVE;
  localparam int CW    = total_cnt_w(H_ACTIVE, V_ACTIVE);
  localparam int LW    = $clog2(H_ACTIVE + 2);
  localparam int SKW   = (SKIP > 1) ? $clog2(SKIP) : 1;

  logic             vsync_reg, vsync_prev_reg, href_reg, href_prev_reg;
  logic [7:0]       din_reg, hi_byte_reg;
  logic             toggle_reg;
  cap_state_t       state_reg, state_next;
  logic [SKW-1:0]   skip_cnt_reg, skip_cnt_next;
  logic [CW-1:0]    pix_cnt_reg;
  logic [LW-1:0]    line_pix_reg;
  logic             ovf_seen_reg, sop_pend_reg;

  logic vs_rise, href_fall, capturing, frame_end, frame_start;
  logic pix_stb, pix_accept, pix_last, cnt_full, short_frame;
  logic pack_flush, pack_fire;

  assign vs_rise     = vsync_reg & ~vsync_prev_reg;
  assign href_fall   = href_prev_reg & ~href_reg;
  assign capturing   = (state_reg == CAPTURE);
  assign pix_stb     = capturing & href_reg & toggle_reg;
  assign cnt_full    = (pix_cnt_reg == CW'(TOTAL));
  assign pix_accept  = pix_stb & ~cnt_full;
  assign pix_last    = pix_accept & (pix_cnt_reg == CW'(TOTAL - 1));
  assign frame_end   = capturing & vs_rise;
  // An eop word landing on the frame-end edge wins; no flush then.
  assign short_frame = frame_end & ~cnt_full & ~pix_last;
  assign pack_flush  = pix_last | (short_frame & (pix_accept | (pix_cnt_reg != '0)));
  assign frame_start = vs_rise & (state_next == CAPTURE);

  always_comb begin
    state_next    = state_reg;
    skip_cnt_next = skip_cnt_reg;
    case (state_reg)
      IDLE: if (enable) state_next = WAIT_VS;
      WAIT_VS: begin
        if (!enable)     state_next = IDLE;
        else if (vs_rise) state_next = CAPTURE;
      end
      CAPTURE: begin
        if (vs_rise) begin
          skip_cnt_next = '0;
          if (SKIP > 0) state_next = SKIPPING;
          else          state_next = enable ? CAPTURE : IDLE;
        end
      end
      SKIPPING: begin
        if (vs_rise) begin
          if (skip_cnt_reg == SKW'(SKIP - 1)) state_next = enable ? CAPTURE : IDLE;
          else                                skip_cnt_next = skip_cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_reg      <= 1'b0;
      vsync_prev_reg <= 1'b0;
      href_reg       <= 1'b0;
      href_prev_reg  <= 1'b0;
      din_reg        <= '0;
      hi_byte_reg    <= '0;
      toggle_reg     <= 1'b0;
      state_reg      <= IDLE;
      skip_cnt_reg   <= '0;
      pix_cnt_reg    <= '0;
      line_pix_reg   <= '0;
      ovf_seen_reg   <= 1'b0;
      sop_pend_reg   <= 1'b0;
      dout_sop       <= 1'b0;
      dout_eop       <= 1'b0;
      frame_done     <= 1'b0;
      line_err       <= 1'b0;
      frame_err      <= 1'b0;
      frame_cnt      <= '0;
    end else begin
      vsync_reg      <= vsync;
      vsync_prev_reg <= vsync_reg;
      href_reg       <= href;
      href_prev_reg  <= href_reg;
      din_reg        <= din;
      toggle_reg     <= href_reg & ~toggle_reg;
      if (href_reg & ~toggle_reg) hi_byte_reg <= din_reg;

      state_reg    <= state_next;
      skip_cnt_reg <= skip_cnt_next;

      if (frame_start) begin
        pix_cnt_reg  <= '0;
        ovf_seen_reg <= 1'b0;
        sop_pend_reg <= 1'b1;
      end else begin
        if (pix_accept)          pix_cnt_reg  <= pix_cnt_reg + 1'b1;
        if (pix_stb & cnt_full)  ovf_seen_reg <= 1'b1;
        if (pack_fire)           sop_pend_reg <= 1'b0;
      end

      if (href_fall | frame_start)
        line_pix_reg <= '0;
      else if (pix_stb && line_pix_reg != LW'(H_ACTIVE + 1))
        line_pix_reg <= line_pix_reg + 1'b1;

      // toggle_reg still set at the fall means a dangling high byte.
      line_err   <= capturing & href_fall & ((line_pix_reg != LW'(H_ACTIVE)) | toggle_reg);
      frame_err  <= (pix_stb & cnt_full & ~ovf_seen_reg) | short_frame;
      dout_sop   <= pack_fire & sop_pend_reg;
      dout_eop   <= pack_flush;
      frame_done <= pack_flush;
      if (pack_flush) frame_cnt <= frame_cnt + 1'b1;
    end
  end

  pix_word_packer #(.DOUT_W(DOUT_W)) u_packer (
    .clk      (clk),
    .rst      (rst),
    .pix_vld  (pix_accept),
    .pix      ({hi_byte_reg, din_reg}),
    .flush    (pack_flush),
    .fire     (pack_fire),
    .word     (dout),
    .word_vld (dout_vld)
  );

endmodule

// File: doc/cmos_pack_capture.md
# cmos_pack_capture

Parametrised camera capture block that replaces the fixed 8-bit-to-128-bit capture stage between the OV5640 DVP pins and the DDR3 write port. It assembles byte pairs into RGB565 pixels and packs them MSB-first into DOUT_W-bit words tagged with sop/eop. Over the old stage it adds:
- frame decimation;
- per-line and per-frame length checking;
- padded flush of short frames, so the frame buffer writer always sees a terminated packet.

## Interface
Parameters:
- DOUT_W, 128, output word width; must be a multiple of 16.
- H_ACTIVE, 1280, expected pixels per line.
- V_ACTIVE, 720, expected lines per frame.
- SKIP, 0, number of frames dropped after each captured frame (0 captures every frame).

Ports:
- clk  in  1  pixel clock (buffered cmos pclk); the only clock.
- rst  in  1  reset, synchronous, active-high.
- enable  in  1  capture enable (sensor config done).
- vsync  in  1  sensor frame sync; a rising edge marks frame start.
- href  in  1  sensor line valid.
- din  in  8  sensor byte; first byte of a pair is the pixel high byte.
- dout  out  DOUT_W  packed pixels; first pixel in [DOUT_W-1:DOUT_W-16].
- dout_vld  out  1  word valid, one-cycle pulse per word.
- dout_sop  out  1  first word of frame, qualified by dout_vld.
- dout_eop  out  1  last word of frame, qualified by dout_vld.
- frame_done  out  1  one-cycle pulse coincident with the eop word.
- line_err  out  1  one-cycle pulse: line length ≠ H_ACTIVE, or odd byte count.
- frame_err  out  1  one-cycle pulse: frame short or long.
- frame_cnt  out  16  number of captured frames, wraps at 65535→0.

## Operation
- vsync, href and din are registered once internally. An edge detector on the registered vsync yields vs_rise.
- FSM states: IDLE, WAIT_VS, CAPTURE, SKIPPING.
  - IDLE → WAIT_VS when enable=1.
  - WAIT_VS → CAPTURE on vs_rise, if enable=1. If enable=0 in WAIT_VS, return to IDLE.
  - CAPTURE → SKIPPING on the next vs_rise (frame end). If SKIP=0, go instead to CAPTURE if enable=1, else to IDLE.
  - SKIPPING counts vs_rise edges. After SKIP edges it goes to CAPTURE if enable=1, else to IDLE. The final skip edge is also the start of the captured frame.
- Dropping enable during CAPTURE does not abort the frame. The frame completes, and enable is evaluated only at the frame-end vs_rise.
- Byte pairing: while href=1, bytes alternate between high and low. The pair toggle clears on every href fall.
- Pixel packing: a 16-bit pixel is shifted into the word register. When PIX_PER_WORD=DOUT_W/16 pixels have accumulated, the word is emitted.
- pix_cnt counts pixels in the frame, range 0..H_ACTIVE*V_ACTIVE.
  - The word containing pixel number H_ACTIVE*V_ACTIVE carries eop.
  - Pixels after that are discarded and raise frame_err once per frame.
- Short frame: on a frame-end vs_rise with 0 < pix_cnt < total, the partial word is flushed with zero padding in the low bits, dout_eop=1 and frame_err=1.
  - If pix_cnt is a multiple of PIX_PER_WORD, one all-zero word with eop is emitted instead.
  - If pix_cnt=0, no word is emitted, frame_err=1 and frame_cnt does not increment.
- Line check: on each href fall, if the line pixel count ≠ H_ACTIVE or a dangling high byte exists, line_err pulses. A dangling byte is discarded.
- frame_cnt increments on every eop, including flushed short frames.

## Timing
- Every output resets to 0. On reset the FSM goes to IDLE and all counters clear. Reset mid-frame drops the frame with no eop; capture resumes only at the next vs_rise after enable.
- Latency: din pin sample at edge k; input register at k; word emitted with dout_vld high after edge k+1. Pin to dout_vld is 2 clk.
- Flush word: dout_vld rises 2 clk after the vsync pin rises.
- There is no back-pressure. The downstream must accept one word per PIX_PER_WORD*2 clk.
- If an eop word and a frame-end vs_rise fall in the same cycle, the eop word takes precedence and no flush occurs.

## Structure
- Package cmos_cap_pkg holds:
  - the state enum;
  - PIX_W=16;
  - the function computing PIX_PER_WORD and the total-pixel counter width ($clog2(H_ACTIVE*V_ACTIVE+1)).
- One sub-module, pix_word_packer, implements the shift register, fill counter and padded flush, with ports for pixel-in, flush, word-out and vld.

## Test plan
- H_ACTIVE=16, V_ACTIVE=2, DOUT_W=128, incrementing bytes 0x00.. → 4 words, with the first = 0x0001_0203_..._0E0F. sop on word 1, eop and frame_done on word 4, frame_cnt=1, no errors.
- SKIP=2, 6 frames with enable=1 → frames 1 and 4 captured, frame_cnt=2.
- Frame of 20 pixels instead of 32 → third word = pixels 17..20 followed by 4 zero pixels, with eop and frame_err. A 16-pixel short frame → extra all-zero eop word.
- One line of 15 pixels plus 1 odd byte → line_err pulse at href fall; dangling byte absent from dout.
- Enable dropped mid-frame → that frame completes with eop, then no dout_vld for the next frame. Re-enable → capture restarts at the next vs_rise.
- rst asserted mid-frame → all outputs 0 next cycle, no eop emitted. The next vs_rise produces a clean sop.
